// File: rtl/fc_layer_sequencer.sv
// Frame sequencer for one fully connected layer: paces exactly INPUT_SIZE beats into
// the layer, captures and post-processes its NUM_NEURONS results, then drains them serially.
module fc_layer_sequencer #(
  parameter int NUM_NEURONS = 16,
  parameter int INPUT_SIZE  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int ACC_WIDTH   = 32,
  parameter int OUT_SHIFT   = 0,
  parameter int RELU_EN     = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic signed [DATA_WIDTH-1:0] s_data,
  input  logic                         s_last,
  output logic                         fc_valid_in,
  output logic signed [DATA_WIDTH-1:0] fc_data,
  input  logic signed [ACC_WIDTH-1:0]  fc_out [NUM_NEURONS],
  input  logic                         fc_valid_out,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic signed [DATA_WIDTH-1:0] m_data,
  output logic                         m_last,
  output logic                         busy,
  output logic                         err_len,
  output logic                         err_spurious,
  output logic [15:0]                  frame_count
);

  // state   | meaning
  // LOAD    | accepting input elements, one fc_valid_in beat per element
  // WAIT_FC | frame issued, waiting for the layer's fc_valid_out
  // DRAIN   | streaming buffered results to the next layer
  typedef enum logic [1:0] {LOAD, WAIT_FC, DRAIN} state_t;

  localparam int IW = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam int OW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam logic [IW-1:0] IN_LAST  = IW'(INPUT_SIZE - 1);
  localparam logic [OW-1:0] OUT_LAST = OW'(NUM_NEURONS - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  state_t                       state, state_next;
  logic [IW-1:0]                in_cnt;
  logic [OW-1:0]                out_idx;
  logic                         in_fire, in_last, out_fire, out_last;
  logic signed [DATA_WIDTH-1:0] res_buf  [NUM_NEURONS];
  logic signed [DATA_WIDTH-1:0] proc_res [NUM_NEURONS];

  function automatic logic signed [DATA_WIDTH-1:0] post_proc(input logic signed [ACC_WIDTH-1:0] acc);
    logic signed [ACC_WIDTH-1:0] r;
    r = acc >>> OUT_SHIFT;
    if ((RELU_EN != 0) && r[ACC_WIDTH-1]) r = '0;
    if (r > SAT_MAX)      r = SAT_MAX;
    else if (r < SAT_MIN) r = SAT_MIN;
    return r[DATA_WIDTH-1:0];
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_NEURONS; i++) proc_res[i] = post_proc(fc_out[i]);
  end

  always_comb begin
    in_last    = (in_cnt == IN_LAST);
    out_last   = (out_idx == OUT_LAST);
    in_fire    = s_valid && s_ready;
    m_valid    = (state == DRAIN);
    m_data     = m_valid ? res_buf[out_idx] : '0;
    m_last     = m_valid && out_last;
    busy       = (state != LOAD) || (in_cnt != '0);
    out_fire   = m_valid && m_ready;
    state_next = state;
    case (state)
      LOAD:    if (in_fire && in_last) state_next = WAIT_FC;
      WAIT_FC: if (fc_valid_out) state_next = DRAIN;
      DRAIN:   if (out_fire && out_last) state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= LOAD;
      in_cnt       <= '0;
      out_idx      <= '0;
      s_ready      <= 1'b0;
      fc_valid_in  <= 1'b0;
      fc_data      <= '0;
      err_len      <= 1'b0;
      err_spurious <= 1'b0;
      frame_count  <= '0;
    end else begin
      state        <= state_next;
      // s_ready is registered, so it follows the state we are about to enter
      s_ready      <= (state_next == LOAD);
      fc_valid_in  <= in_fire;
      err_len      <= in_fire && (s_last != in_last);
      err_spurious <= fc_valid_out && (state != WAIT_FC);
      if (in_fire) begin
        fc_data <= s_data;
        in_cnt  <= in_last ? '0 : in_cnt + 1'b1;
      end
      if (out_fire) begin
        out_idx <= out_last ? '0 : out_idx + 1'b1;
        if (out_last) frame_count <= frame_count + 1'b1;
      end
    end
  end

  // Buffer needs no reset: m_data is gated by DRAIN, which is only reached via a fresh capture.
  always_ff @(posedge clk) begin
    if (state == WAIT_FC && fc_valid_out) res_buf <= proc_res;
  end

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Bench for fc_layer_sequencer: two instances (shift/ReLU and raw/saturating) share one
// stimulus stream; expected results come from a vector table pushed to a scoreboard queue.
module tb_fc_layer_sequencer;
  localparam int N = 16, IN = 16, DW = 16, AW = 32, FC_LAT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, s_valid, s_last, fc_valid_out, m_ready;
  logic signed [DW-1:0] s_data;
  logic signed [AW-1:0] fc_out_a [N];
  logic signed [AW-1:0] fc_out_b [N];
  logic s_ready_a, fc_valid_in_a, m_valid_a, m_last_a, busy_a, err_len_a, err_spurious_a;
  logic s_ready_b, fc_valid_in_b, m_valid_b, m_last_b, busy_b, err_len_b, err_spurious_b;
  logic signed [DW-1:0] fc_data_a, m_data_a, fc_data_b, m_data_b;
  logic [15:0] frame_count_a, frame_count_b;

  fc_layer_sequencer #(.NUM_NEURONS(N), .INPUT_SIZE(IN), .DATA_WIDTH(DW), .ACC_WIDTH(AW),
                       .OUT_SHIFT(8), .RELU_EN(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_a), .s_data(s_data),
    .s_last(s_last), .fc_valid_in(fc_valid_in_a), .fc_data(fc_data_a), .fc_out(fc_out_a),
    .fc_valid_out(fc_valid_out), .m_valid(m_valid_a), .m_ready(m_ready), .m_data(m_data_a),
    .m_last(m_last_a), .busy(busy_a), .err_len(err_len_a), .err_spurious(err_spurious_a),
    .frame_count(frame_count_a));

  fc_layer_sequencer #(.NUM_NEURONS(N), .INPUT_SIZE(IN), .DATA_WIDTH(DW), .ACC_WIDTH(AW),
                       .OUT_SHIFT(0), .RELU_EN(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_b), .s_data(s_data),
    .s_last(s_last), .fc_valid_in(fc_valid_in_b), .fc_data(fc_data_b), .fc_out(fc_out_b),
    .fc_valid_out(fc_valid_out), .m_valid(m_valid_b), .m_ready(m_ready), .m_data(m_data_b),
    .m_last(m_last_b), .busy(busy_b), .err_len(err_len_b), .err_spurious(err_spurious_b),
    .frame_count(frame_count_b));

  typedef struct {
    logic signed [AW-1:0] acc_a, acc_b;
    logic signed [DW-1:0] exp_a, exp_b;
  } vec_t;
  typedef struct {
    logic signed [DW-1:0] a, b;
    logic                 last;
  } exp_t;

  vec_t tbl [2][N];
  exp_t sb [$];
  int   n_checks = 0, n_fail = 0, fc_exp = 0;
  int   beats_a = 0, beats_b = 0;

  // Beat counters catch any fc_valid_in outside an accepted element.
  always @(negedge clk) begin
    if (fc_valid_in_a) beats_a++;
    if (fc_valid_in_b) beats_b++;
  end

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int aa, input int ab, input int ea, input int eb);
    vec_t v;
    v.acc_a = aa; v.acc_b = ab; v.exp_a = 16'(ea); v.exp_b = 16'(eb);
    return v;
  endfunction

  task automatic run_frame(input int set, input logic [IN-1:0] last_mask, input bit stall,
                           input int spur_at, input int abort_after);
    int ba, bb, w, hs, cyc;
    logic signed [DW-1:0] held;
    logic held_last;
    bit held_v;
    exp_t e;
    for (int i = 0; i < N; i++) begin
      fc_out_a[i] = tbl[set][i].acc_a;
      fc_out_b[i] = tbl[set][i].acc_b;
      e.a = tbl[set][i].exp_a; e.b = tbl[set][i].exp_b; e.last = (i == N-1);
      sb.push_back(e);
    end
    ba = beats_a; bb = beats_b;
    for (int k = 0; k < IN; k++) begin
      if (k == spur_at) begin
        fc_valid_out = 1'b1;
        @(negedge clk);
        fc_valid_out = 1'b0;
        chk("err_spurious_pulse", err_spurious_a, 1);
        chk("err_spurious_pulse_b", err_spurious_b, 1);
        chk("no_m_valid_on_spurious", m_valid_a, 0);
        @(negedge clk);
        chk("err_spurious_one_cycle", err_spurious_a, 0);
        chk("still_loading_after_spurious", s_ready_a, 1);
      end
      s_valid = 1'b1; s_data = 16'($urandom); s_last = last_mask[k]; w = 0;
      while (!s_ready_a && w < 100) begin @(negedge clk); w++; end
      chk("s_ready_wait", s_ready_a, 1);
      @(negedge clk);
      s_valid = 1'b0; s_last = 1'b0;
      chk("fc_valid_in_a", fc_valid_in_a, 1);
      chk("fc_data_a", fc_data_a, s_data);
      chk("fc_data_b", fc_data_b, s_data);
      chk("err_len", err_len_a, last_mask[k] != (k == IN-1));
    end
    chk("s_ready_drop", s_ready_a, 0);
    chk("busy_wait_fc", busy_a, 1);
    repeat (FC_LAT) begin
      @(negedge clk);
      chk("no_m_valid_wait_fc", m_valid_a, 0);
    end
    chk("beats_a", beats_a - ba, IN);
    chk("beats_b", beats_b - bb, IN);
    fc_valid_out = 1'b1;
    @(negedge clk);
    fc_valid_out = 1'b0;
    chk("m_valid_rise", m_valid_a, 1);
    chk("no_spurious_on_capture", err_spurious_a, 0);
    hs = 0; cyc = 0; held_v = 0; held = '0; held_last = 1'b0;
    while (sb.size() > 0 && cyc < 200 && !(abort_after >= 0 && hs == abort_after)) begin
      m_ready = stall ? (cyc % 2 == 0) : 1'b1;
      if (held_v) begin
        chk("stall_hold_data", m_data_a, held);
        chk("stall_hold_last", m_last_a, held_last);
      end
      held_v = 0;
      chk("s_ready_low_in_drain", s_ready_a, 0);
      if (m_valid_a && m_ready) begin
        e = sb.pop_front();
        chk("m_data_a", m_data_a, e.a);
        chk("m_data_b", m_data_b, e.b);
        chk("m_last_a", m_last_a, e.last);
        chk("m_valid_b", m_valid_b, 1);
        hs++;
      end else if (m_valid_a) begin
        held = m_data_a; held_last = m_last_a; held_v = 1;
      end else begin
        chk("m_valid_in_drain", m_valid_a, 1);
      end
      @(negedge clk);
      cyc++;
    end
    if (abort_after >= 0 && hs == abort_after) begin
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_m_valid", m_valid_a, 0);
      chk("abort_frame_count", frame_count_a, 0);
      chk("abort_s_ready", s_ready_a, 0);
      chk("abort_busy", busy_a, 0);
      rst_n = 1'b1;
      sb.delete();
      fc_exp = 0;
      @(negedge clk);
      chk("s_ready_after_abort", s_ready_a, 1);
    end else begin
      chk("drain_complete", sb.size(), 0);
      chk("s_ready_rise", s_ready_a, 1);
      chk("m_valid_done", m_valid_a, 0);
      chk("busy_idle", busy_a, 0);
      fc_exp++;
      chk("frame_count_a", frame_count_a, fc_exp);
      chk("frame_count_b", frame_count_b, fc_exp);
    end
    m_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      tbl[0][i] = mk(i*256 - 1024, i*256 - 1024, (i <= 4) ? 0 : i - 4, i*256 - 1024);
      tbl[1][i] = mk(i*100, -i*100, (i*100) / 256, -i*100);
    end
    tbl[0][0] = mk(-1024, 32'h7FFF_FFFF,  0,  32767);
    tbl[0][1] = mk(-768,  32'h8000_0000,  0, -32768);
    tbl[0][2] = mk(-512,  -5,             0,     -5);
    tbl[1][0] = mk(32'h0100_0000, -32769, 32767, -32768);
    tbl[1][1] = mk(-300,           32768,     0,  32767);
    tbl[1][2] = mk(511,               -1,     1,     -1);
    tbl[1][3] = mk(255,            32767,     0,  32767);
    tbl[1][4] = mk(8388352,       -32768, 32767, -32768);
    tbl[1][5] = mk(8388608,        12345, 32767,  12345);
    tbl[1][6] = mk(1000,              -7,     3,     -7);
    tbl[1][7] = mk(0,                  0,     0,      0);

    rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0; fc_valid_out = 1'b0; m_ready = 1'b0;
    for (int i = 0; i < N; i++) begin fc_out_a[i] = '0; fc_out_b[i] = '0; end
    repeat (3) @(negedge clk);
    chk("rst_s_ready", s_ready_a, 0);
    chk("rst_fc_valid_in", fc_valid_in_a, 0);
    chk("rst_fc_data", fc_data_a, 0);
    chk("rst_m_valid", m_valid_a, 0);
    chk("rst_m_data", m_data_a, 0);
    chk("rst_m_last", m_last_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_err_len", err_len_a, 0);
    chk("rst_err_spurious", err_spurious_a, 0);
    chk("rst_frame_count", frame_count_a, 0);
    chk("rst_b_outputs", {s_ready_b, fc_valid_in_b, m_valid_b, m_last_b, busy_b,
                          err_len_b, err_spurious_b}, 0);
    chk("rst_b_data", {fc_data_b, m_data_b, frame_count_b}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("s_ready_after_release", s_ready_a, 1);

    run_frame(0, 16'h8000, 1'b0, -1, -1);  // basic frame + saturation vectors
    run_frame(1, 16'h8000, 1'b1, -1, -1);  // 1,0,1,0 backpressure
    run_frame(0, 16'h8200, 1'b0, -1, -1);  // early s_last on the 10th element
    run_frame(1, 16'h0000, 1'b0,  3, -1);  // missing s_last, spurious result at in_cnt=3
    run_frame(0, 16'h8000, 1'b0, -1,  5);  // reset after 5 outputs accepted
    run_frame(0, 16'h8000, 1'b0, -1, -1);  // clean frame after reset

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
